ckegen_multi: RTL and testbench

- Multi-channel, runtime-programmable clock-enable generator; successor to the single fixed-period enable generator.
- Each of CH channels emits a one-cycle cke pulse every T enabled clock cycles. T is loadable per channel, and each channel runs periodic or one-shot.
- A global sync strobe phase-aligns all channels.
- Sits between the system clock domain and slow peripherals (UART baud, debounce, display refresh, timers) that gate on cke instead of derived clocks.

---
 rtl/ckegen_multi_if.sv | 41 ++++
 rtl/ckegen_multi.sv | 125 ++++++++++++
 tb/tb_ckegen_multi.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ckegen_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : ckegen_multi_if
// Description : Control/status bundle for the multi-channel clock-enable
//               generator. The master side drives the enables, period
//               values and strobes. The slave side (the generator) returns
//               the per-channel cke pulses and busy flags.
//   ena      master->slave  1     global enable
//   ch_ena   master->slave  CH    per-channel enable
//   period   master->slave  CH*W  per-channel period, channel i at [i*W +: W]
//   load     master->slave  CH    per-channel load/restart strobe
//   oneshot  master->slave  CH    mode captured on load (1 = one-shot)
//   sync     master->slave  1     restart all channels with current periods
//   cke      slave->master  CH    registered one-cycle enable pulse
//   busy     slave->master  CH    channel running
// Revision    : 1.0 - initial release
// ============================================================================
interface ckegen_multi_if #(
   parameter int CH = 4,
   parameter int W  = 26
);
   logic            ena;
   logic [CH-1:0]   ch_ena;
   logic [CH*W-1:0] period;
   logic [CH-1:0]   load;
   logic [CH-1:0]   oneshot;
   logic            sync;
   logic [CH-1:0]   cke;
   logic [CH-1:0]   busy;

   modport master (
      output ena, ch_ena, period, load, oneshot, sync,
      input  cke, busy
   );

   modport slave (
      input  ena, ch_ena, period, load, oneshot, sync,
      output cke, busy
   );
endinterface
`default_nettype wire

// File: rtl/ckegen_multi.sv
`default_nettype none
// ============================================================================
// Module      : ckegen_multi
// Description : Multi-channel, runtime-programmable clock-enable generator.
//               Each channel emits a one-cycle cke pulse every T active
//               cycles. T and the periodic/one-shot mode are loaded per
//               channel. A global sync strobe restarts every channel so
//               that all channels are phase-aligned.
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of ckegen_multi_if (enables, periods, strobes,
//         cke and busy outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module ckegen_multi #(
   parameter int CH        = 4,
   parameter int W         = 26,
   parameter int DEFAULT_T = 50000000
) (
   input  logic          clk,
   input  logic          rst,
   ckegen_multi_if.slave bus
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (CH < 1) begin : g_bad_ch
      $error("ckegen_multi: CH must be >= 1");
   end

   if (W < 1 || W > 62) begin : g_bad_w
      $error("ckegen_multi: W must be in 1..62");
   end

   if (DEFAULT_T < 1 ||
       longint'(DEFAULT_T) > ((longint'(1) << W) - longint'(1))) begin : g_bad_default_t
      $error("ckegen_multi: DEFAULT_T must be in 1..2^W-1");
   end

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [W-1:0] c_zero       = '0;
   localparam logic [W-1:0] c_one        = W'(1);
   localparam logic [W-1:0] c_default_t  = W'(DEFAULT_T);
   localparam logic [W-1:0] c_default_m1 = W'(DEFAULT_T - 1);

   // Per-channel outputs gathered here so each bit has exactly one driver.
   logic [CH-1:0] cke_w;
   logic [CH-1:0] busy_w;

   assign bus.cke  = cke_w;
   assign bus.busy = busy_w;

   // ------------------------------------------------------------------------
   // Channel array
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < CH; i++) begin : g_ch

      logic [W-1:0] per_r;     // latched period (0 behaves as 1)
      logic [W-1:0] cnt;       // active cycles left before next pulse, minus 1
      logic         run;       // channel running
      logic         os_r;      // one-shot mode
      logic         cke_r;     // registered enable pulse

      logic [W-1:0] per_in;    // this channel's slice of the period bus
      logic [W-1:0] te_m1;     // reload value from the latched period
      logic [W-1:0] load_m1;   // reload value from the incoming period
      logic         active;    // channel counts in this cycle
      logic         hit;       // counter has reached its terminal value

      assign per_in = bus.period[i*W +: W];

      // A period of zero is folded onto one, so the reload value is zero
      // for both 0 and 1 and the channel pulses on every active cycle.
      assign te_m1   = (per_r  == c_zero) ? c_zero : (per_r  - c_one);
      assign load_m1 = (per_in == c_zero) ? c_zero : (per_in - c_one);

      // load and sync take priority over counting, so they also suppress it.
      assign active = bus.ena & bus.ch_ena[i] & run & ~bus.load[i] & ~bus.sync;
      assign hit    = (cnt == c_zero);

      always_ff @(posedge clk) begin
         if (rst) begin
            per_r <= c_default_t;
            cnt   <= c_default_m1;
            run   <= 1'b1;
            os_r  <= 1'b0;
            cke_r <= 1'b0;
         end else if (bus.load[i]) begin
            per_r <= per_in;
            os_r  <= bus.oneshot[i];
            run   <= 1'b1;
            cnt   <= load_m1;
            cke_r <= 1'b0;
         end else if (bus.sync) begin
            // Restart the phase but leave run alone: a one-shot that has
            // already fired stays idle until it is reloaded.
            cnt   <= te_m1;
            cke_r <= 1'b0;
         end else if (active) begin
            cke_r <= hit;
            if (hit) begin
               cnt <= te_m1;
               if (os_r) begin
                  run <= 1'b0;
               end
            end else begin
               cnt <= cnt - c_one;
            end
         end else begin
            // Paused or idle: the counter holds so no phase is lost.
            cke_r <= 1'b0;
         end
      end

      // run is itself a register, so busy falls in the same cycle that the
      // final one-shot pulse is high.
      assign cke_w[i]  = cke_r;
      assign busy_w[i] = run;
   end

endmodule
`default_nettype wire

// File: tb/tb_ckegen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_ckegen_multi
// Description : Self-checking bench for ckegen_multi. A stimulus process
//               drives the interface once per cycle and pushes the outputs
//               predicted by a behavioural model into a queue. A monitor
//               pops one entry per clock and compares it with cke/busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ckegen_multi;

   localparam int CH        = 2;
   localparam int W         = 4;
   localparam int DEFAULT_T = 5;

   logic clk;
   logic rst;

   ckegen_multi_if #(.CH(CH), .W(W)) bus ();

   ckegen_multi #(
      .CH        (CH),
      .W         (W),
      .DEFAULT_T (DEFAULT_T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model: per channel, the latched period, mode, running flag
   // and the number of active cycles counted since the last restart.
   // ------------------------------------------------------------------------
   int m_per   [CH];
   bit m_os    [CH];
   bit m_run   [CH];
   int m_since [CH];

   logic [2*CH-1:0] exp_q [$];   // {cke, busy} expected after each edge

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   // Apply one cycle of inputs and predict the outputs after the next edge.
   task automatic step(input bit r, input bit e, input logic [CH-1:0] ce,
                       input logic [CH-1:0] ld, input logic [CH-1:0] os,
                       input logic [CH*W-1:0] pv, input bit sy);
      logic [CH-1:0] ck;
      logic [CH-1:0] bz;
      @(negedge clk);
      rst         = r;
      bus.ena     = e;
      bus.ch_ena  = ce;
      bus.load    = ld;
      bus.oneshot = os;
      bus.period  = pv;
      bus.sync    = sy;
      for (int i = 0; i < CH; i++) begin
         int p;
         int te;
         p     = int'(pv[i*W +: W]);
         ck[i] = 1'b0;
         if (r) begin
            m_per[i]   = DEFAULT_T;
            m_os[i]    = 1'b0;
            m_run[i]   = 1'b1;
            m_since[i] = 0;
         end else if (ld[i]) begin
            m_per[i]   = p;
            m_os[i]    = os[i];
            m_run[i]   = 1'b1;
            m_since[i] = 0;
         end else if (sy) begin
            m_since[i] = 0;
         end else if (e && ce[i] && m_run[i]) begin
            te         = (m_per[i] == 0) ? 1 : m_per[i];
            m_since[i] = m_since[i] + 1;
            if (m_since[i] >= te) begin
               ck[i]      = 1'b1;
               m_since[i] = 0;
               if (m_os[i]) m_run[i] = 1'b0;
            end
         end
         bz[i] = m_run[i];
      end
      exp_q.push_back({ck, bz});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, '1, '0, '0, '0, 1'b0);
   endtask

   task automatic pause_ena(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '1, '0, '0, '0, 1'b0);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: one prediction per edge, compared after the edge settles.
   // ------------------------------------------------------------------------
   always @(posedge clk) begin
      logic [2*CH-1:0] exp;
      #1;
      cycle = cycle + 1;
      if (exp_q.size() > 0) begin
         exp     = exp_q.pop_front();
         vectors = vectors + 1;
         if ({bus.cke, bus.busy} !== exp) begin
            miscompares = miscompares + 1;
            if (miscompares <= 40)
               $display("FAIL cke_busy cycle %0d: got cke=%b busy=%b, expected cke=%b busy=%b",
                        cycle, bus.cke, bus.busy, exp[2*CH-1:CH], exp[CH-1:0]);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst         = 1'b1;
      bus.ena     = 1'b0;
      bus.ch_ena  = '0;
      bus.load    = '0;
      bus.oneshot = '0;
      bus.period  = '0;
      bus.sync    = 1'b0;

      // Reset defaults: both channels pulse every DEFAULT_T cycles.
      step(1'b1, 1'b1, '1, '0, '0, '0, 1'b0);
      step(1'b1, 1'b1, '1, '0, '0, '0, 1'b0);
      idle(17);

      // ch0 periodic T=3, ch1 one-shot T=4, then a long silent stretch.
      step(1'b0, 1'b1, '1, 2'b11, 2'b10, {4'd4, 4'd3}, 1'b0);
      idle(30);

      // Pause with ena low: phase held, no pulses while paused.
      step(1'b0, 1'b1, '1, 2'b01, 2'b00, {4'd0, 4'd6}, 1'b0);
      idle(2);
      pause_ena(10);
      idle(8);

      // Different phases, then sync; then load[0] together with sync.
      step(1'b0, 1'b1, '1, 2'b11, 2'b00, {4'd5, 4'd3}, 1'b0);
      idle(7);
      step(1'b0, 1'b1, '1, 2'b00, 2'b00, '0, 1'b1);
      idle(12);
      step(1'b0, 1'b1, '1, 2'b01, 2'b00, {4'd0, 4'd2}, 1'b1);
      idle(8);

      // Sync must not revive a fired one-shot.
      step(1'b0, 1'b1, '1, 2'b10, 2'b10, {4'd2, 4'd0}, 1'b0);
      idle(4);
      step(1'b0, 1'b1, '1, 2'b00, 2'b00, '0, 1'b1);
      idle(6);

      // Period 0 and 1: continuous cke while active; ch_ena gaps.
      step(1'b0, 1'b1, '1, 2'b11, 2'b00, {4'd1, 4'd0}, 1'b0);
      idle(4);
      step(1'b0, 1'b1, 2'b01, '0, '0, '0, 1'b0);
      step(1'b0, 1'b1, 2'b10, '0, '0, '0, 1'b0);
      idle(3);

      // Maximum period 2^W-1 on both channels.
      step(1'b0, 1'b1, '1, 2'b11, 2'b00, {4'd15, 4'd15}, 1'b0);
      idle(35);

      // Reset during a pending one-shot and mid-count.
      step(1'b0, 1'b1, '1, 2'b11, 2'b11, {4'd7, 4'd9}, 1'b0);
      idle(3);
      step(1'b1, 1'b1, '1, '0, '0, '0, 1'b0);
      idle(12);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [CH-1:0]   ce;
         logic [CH-1:0]   ld;
         logic [CH-1:0]   os;
         logic [CH*W-1:0] pv;
         bit              r;
         bit              e;
         bit              sy;
         for (int i = 0; i < CH; i++) begin
            ce[i] = ($urandom_range(0, 4) != 0);
            ld[i] = ($urandom_range(0, 19) == 0);
            os[i] = ($urandom_range(0, 2) == 0);
         end
         pv = CH*W'($urandom);
         r  = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 7) != 0);
         sy = ($urandom_range(0, 49) == 0);
         step(r, e, ce, ld, os, pv, sy);
      end

      // Drain the scoreboard.
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares = miscompares + 1;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
